// File: rtl/key_event_arbiter_if.sv
// Event handshake between the key arbiter (master) and the control unit (slave).
interface key_event_arbiter_if #(
    parameter int unsigned KEY_W = 2
);
    logic             evt_valid;
    logic [KEY_W-1:0] evt_key;
    logic             evt_ready;

    modport master (output evt_valid, output evt_key, input evt_ready);
    modport slave  (input evt_valid, input evt_key, output evt_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Round-robin key arbiter sharing one lockout timer; accepted presses are queued
// as key-index events in a small FIFO.
module key_event_arbiter #(
    parameter int unsigned NUM_KEYS       = 4,
    parameter int unsigned LOCKOUT        = 5_000_000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned KEY_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_KEYS-1:0]  key_in,
    input  logic                 enable,
    key_event_arbiter_if.master  evt,
    output logic                 busy,
    output logic                 overflow,
    input  logic                 overflow_clr
);

    localparam int unsigned KeyW = $clog2(NUM_KEYS);
    localparam int unsigned CntW = $clog2(LOCKOUT + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    localparam logic                ActLow    = (KEY_ACTIVE_LOW != 0);
    localparam logic [NUM_KEYS-1:0] KeyIdle   = {NUM_KEYS{ActLow}};
    localparam logic [CntW-1:0]     CntLoad   = CntW'(LOCKOUT - 1);
    localparam logic [KeyW-1:0]     LastKey   = KeyW'(NUM_KEYS - 1);
    localparam logic [PtrW:0]       FullCount = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLock, StRelease} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [KeyW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [KeyW-1:0]     gnt_q, gnt_d;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] kp;
    logic                grant_any;
    logic [KeyW-1:0]     grant_idx;
    logic                push;

    logic [KeyW-1:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       count_q;
    logic                fifo_valid, fifo_full, pop, wr_en, ovf_set;
    logic                overflow_q;

    // Two-flop synchronizer; idles at the released level so reset looks like "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= KeyIdle;
            sync2_q <= KeyIdle;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign kp = ActLow ? ~sync2_q : sync2_q;

    // First pressed key at or after the round-robin pointer.
    always_comb begin
        int unsigned     j;
        logic [KeyW-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        j         = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            j    = (32'(rr_ptr_q) + i) % NUM_KEYS;
            cand = KeyW'(j);
            if (!grant_any && kp[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && grant_any) begin
                    push     = 1'b1;
                    gnt_d    = grant_idx;
                    rr_ptr_d = (grant_idx == LastKey) ? '0 : grant_idx + 1'b1;
                    cnt_d    = CntLoad;
                    state_d  = StLock;
                end
            end
            StLock: begin
                if (cnt_q == '0) state_d = StRelease;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StRelease: begin
                if (!kp[gnt_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
        end
    end

    assign busy = (state_q != StIdle);

    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign fifo_valid = (count_q != '0);
    assign fifo_full  = (count_q == FullCount);
    assign pop        = fifo_valid && evt.evt_ready;
    assign wr_en      = push && (!fifo_full || pop);
    assign ovf_set    = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= gnt_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            overflow_q <= 1'b0;
        else if (ovf_set)      overflow_q <= 1'b1;
        else if (overflow_clr) overflow_q <= 1'b0;
    end

    assign overflow      = overflow_q;
    assign evt.evt_valid = fifo_valid;
    assign evt.evt_key   = fifo_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: reset, latency, lockout length, bounce,
// round-robin, FIFO overflow and asynchronous reset.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'b1111;
    logic       enable = 1'b1;
    logic       overflow_clr = 1'b0;
    logic       busy, overflow;

    key_event_arbiter_if #(.KEY_W(2)) evt ();

    key_event_arbiter #(
        .NUM_KEYS       (4),
        .LOCKOUT        (8),
        .FIFO_DEPTH     (2),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .enable       (enable),
        .evt          (evt),
        .busy         (busy),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [1:0] ev_q [$];

    // Inputs only change just after rising edges, so a negedge sample predicts the pop.
    always @(negedge clk) begin
        if (rst_n && evt.evt_valid && evt.evt_ready) ev_q.push_back(evt.evt_key);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] mask;
        logic       en;
        int         hold;
        int         exp_n;
        logic [1:0] exp_key;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({name, "_idle_timeout"}, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input string name);
        key_in = 4'b1111;
        step(4);
        wait_idle(name);
        step(3);
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        key_in = ~mask;
        step(hold);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int cnt;
        int w;

        // mask, en, hold, events, key  (pointer starts at 2 when the table runs)
        vecs[0] = '{4'b0001, 1'b1, 12, 1, 2'd0};
        vecs[1] = '{4'b1001, 1'b1, 15, 1, 2'd3};
        vecs[2] = '{4'b0110, 1'b1, 15, 1, 2'd1};
        vecs[3] = '{4'b1000, 1'b1,  3, 1, 2'd3};
        vecs[4] = '{4'b1111, 1'b1, 15, 1, 2'd0};
        vecs[5] = '{4'b0100, 1'b1, 12, 1, 2'd2};
        vecs[6] = '{4'b0011, 1'b1, 15, 1, 2'd0};
        vecs[7] = '{4'b0000, 1'b1, 10, 0, 2'd0};
        vecs[8] = '{4'b0100, 1'b0, 15, 0, 2'd0};

        // Reset with arbitrary keys
        evt.evt_ready = 1'b0;
        key_in = 4'b0101;
        rst_n = 1'b0;
        step(3);
        chk("rst_valid", evt.evt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_key", evt.evt_key, 0);
        key_in = 4'b1111;
        evt.evt_ready = 1'b1;
        rst_n = 1'b1;
        step(50);
        chk("idle_no_events", ev_q.size(), 0);
        chk("idle_valid", evt.evt_valid, 0);
        chk("idle_busy", busy, 0);

        // Single press: latency and hold behaviour
        ev_q.delete();
        key_in = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) chk("lat_before_push", evt.evt_valid, 0);
            if (i == 3) begin
                chk("lat_valid", evt.evt_valid, 1);
                chk("lat_key", evt.evt_key, 2);
                chk("lat_busy", busy, 1);
            end
        end
        @(posedge clk);
        #1;
        step(26);
        chk("held_busy", busy, 1);
        settle("single");
        chk("single_count", ev_q.size(), 1);
        chk("single_key", ev_q[0], 2);
        chk("single_busy_end", busy, 0);

        // Short press on key 0: busy spans 8 LOCK cycles plus one RELEASE cycle
        ev_q.delete();
        key_in = 4'b1110;
        w = 0;
        @(negedge clk);
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("short_busy_seen", busy, 1);
        @(posedge clk);
        #1;
        key_in = 4'b1111;
        cnt = 1;
        w = 0;
        @(negedge clk);
        while (busy && w < 40) begin
            cnt++;
            w++;
            @(negedge clk);
        end
        chk("lock_length", cnt, 9);
        step(1);
        settle("short");
        chk("short_count", ev_q.size(), 1);
        chk("short_key", ev_q[0], 0);

        // Bounce on key 1
        ev_q.delete();
        for (int i = 0; i < 7; i++) begin
            key_in = ((i / 2) % 2 == 0) ? 4'b1101 : 4'b1111;
            step(1);
        end
        press(4'b0010, 20);
        settle("bounce");
        chk("bounce_count", ev_q.size(), 1);
        chk("bounce_key", ev_q[0], 1);

        // Table of single presses / simultaneous presses with the pointer tracked by hand
        for (int v = 0; v < 9; v++) begin
            ev_q.delete();
            enable = vecs[v].en;
            press(vecs[v].mask, vecs[v].hold);
            settle("vec");
            enable = 1'b1;
            chk($sformatf("vec%0d_count", v), ev_q.size(), vecs[v].exp_n);
            if (vecs[v].exp_n > 0 && ev_q.size() > 0)
                chk($sformatf("vec%0d_key", v), ev_q[0], vecs[v].exp_key);
        end

        // Round-robin from a fresh pointer
        pulse_reset();
        ev_q.delete();
        key_in = 4'b0110;
        step(14);
        key_in = 4'b0111;
        step(20);
        settle("rr_a");
        press(4'b1001, 15);
        settle("rr_b");
        chk("rr_count", ev_q.size(), 3);
        chk("rr_first", ev_q[0], 0);
        chk("rr_second", ev_q[1], 3);
        chk("rr_wrap", ev_q[2], 0);

        // Overflow: third press dropped while the consumer stalls
        ev_q.delete();
        evt.evt_ready = 1'b0;
        press(4'b0010, 12);
        settle("ovf1");
        press(4'b0100, 12);
        settle("ovf2");
        chk("ovf_not_yet", overflow, 0);
        press(4'b1000, 12);
        settle("ovf3");
        chk("ovf_set", overflow, 1);
        chk("ovf_head", evt.evt_key, 1);
        evt.evt_ready = 1'b1;
        step(5);
        chk("ovf_drain_count", ev_q.size(), 2);
        chk("ovf_drain_first", ev_q[0], 1);
        chk("ovf_drain_second", ev_q[1], 2);
        chk("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Set wins over a clear on the same edge
        ev_q.delete();
        evt.evt_ready = 1'b0;
        press(4'b0001, 12);
        settle("pri1");
        press(4'b0100, 12);
        settle("pri2");
        key_in = 4'b1101;
        step(2);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        chk("ovf_set_priority", overflow, 1);
        settle("pri3");
        evt.evt_ready = 1'b1;
        step(5);
        chk("pri_drain_count", ev_q.size(), 2);
        chk("pri_drain_first", ev_q[0], 0);
        chk("pri_drain_second", ev_q[1], 2);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;

        // Asynchronous reset in LOCK with an event queued
        ev_q.delete();
        evt.evt_ready = 1'b0;
        key_in = 4'b0111;
        step(6);
        chk("mid_busy_before", busy, 1);
        chk("mid_valid_before", evt.evt_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid_async", evt.evt_valid, 0);
        chk("mid_busy_async", busy, 0);
        chk("mid_overflow_async", overflow, 0);
        key_in = 4'b1111;
        step(2);
        rst_n = 1'b1;
        evt.evt_ready = 1'b1;
        step(2);
        press(4'b0100, 12);
        settle("mid_resume");
        chk("mid_resume_count", ev_q.size(), 1);
        chk("mid_resume_key", ev_q[0], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
